// File: rtl/raw_black_level_pkg.sv
// Shared ISP definitions: control-word bit positions, sideband bits, CFA channel
// indices and the Q4.12 fixed-point unity constant.
package raw_black_level_pkg;

  localparam int unsigned CtrlEnBit    = 0;
  localparam int unsigned CtrlPhaseLo  = 5;
  localparam int unsigned CtrlPhaseHi  = 6;
  localparam int unsigned CtrlBlcBit   = 8;

  localparam int unsigned UserLineBit  = 0;
  localparam int unsigned UserFrameBit = 1;

  localparam int unsigned Q412Frac     = 12;
  localparam logic [15:0] Q412One      = 16'd4096;

  typedef enum logic [1:0] {
    ChGr = 2'd0,
    ChR  = 2'd1,
    ChB  = 2'd2,
    ChGb = 2'd3
  } cfa_ch_e;

endpackage

// File: rtl/raw_cfa_position.sv
// Tracks the Bayer x/y parity of each accepted pixel and produces its CFA channel
// index, already rotated by the configured CFA phase.
module raw_cfa_position
  import raw_black_level_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       accept,
  input  logic       line_start,
  input  logic       frame_start,
  input  logic [1:0] phase,
  output logic [1:0] ch
);

  logic pos_x, pos_y;
  logic pos_x_d, pos_y_d;

  // Frame start is only meaningful together with line start.
  always_comb begin
    pos_x_d = line_start ? 1'b0 : ~pos_x;
    pos_y_d = line_start ? (frame_start ? 1'b0 : ~pos_y) : pos_y;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_x <= 1'b0;
      pos_y <= 1'b0;
      ch    <= 2'd0;
    end else if (accept) begin
      pos_x <= pos_x_d;
      pos_y <= pos_y_d;
      ch    <= {pos_y_d, pos_x_d} ^ phase;
    end
  end

endmodule

// File: rtl/raw_black_level.sv
// Raw Bayer black-level correction: per-channel offset subtract with floor at zero,
// Q4.12 gain with rounding and saturation, and a per-frame clip counter.
module raw_black_level
  import raw_black_level_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PIPELINE   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [7:0]              in_user,
  input  logic                    in_valid,
  output logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [7:0]              out_user,
  output logic                    out_valid,
  input  logic                    in_ready,
  input  logic [15:0]             isp_ctrl,
  input  logic [4*DATA_WIDTH-1:0] blc_offset,
  input  logic [15:0]             blc_gain,
  output logic [23:0]             clip_count
);

  localparam int unsigned PW = DATA_WIDTH + 16;

  logic [1:0]            phase_q;
  logic                  en_raw_q, en_q;
  logic [PIPELINE-1:0]   valid_q;
  logic                  run, accept, frame_start_in, frame_start_s0;
  logic [1:0]            ch_raw;
  cfa_ch_e               ch0;

  logic [DATA_WIDTH-1:0] off_sh_q [4];
  logic [15:0]           gain_sh_q;

  logic [DATA_WIDTH-1:0] data0_q, d1_q, d2_q;
  logic [7:0]            user0_q, user1_q, user2_q;
  logic                  en1_q, en2_q;
  logic [15:0]           gain1_q;
  logic [PW-1:0]         p2_q;
  logic [23:0]           clip_cnt_q;

  logic [DATA_WIDTH-1:0] off_sel, d1_d, stage3_d;
  logic                  clip_d, sat;
  logic [PW:0]           rnd;
  logic [PW-Q412Frac:0]  q;

  logic unused_ctrl;
  assign unused_ctrl = ^{isp_ctrl[15:9], isp_ctrl[7], isp_ctrl[4:1]};

  assign run            = in_ready | ~valid_q[PIPELINE-1];
  assign out_ready      = run;
  assign out_valid      = valid_q[PIPELINE-1];
  assign accept         = run & in_valid;
  assign frame_start_in = in_user[UserLineBit] & in_user[UserFrameBit];
  assign frame_start_s0 = user0_q[UserLineBit] & user0_q[UserFrameBit];
  assign ch0            = cfa_ch_e'(ch_raw);

  raw_cfa_position u_pos (
    .clk         (clk),
    .reset       (reset),
    .accept      (accept),
    .line_start  (in_user[UserLineBit]),
    .frame_start (in_user[UserFrameBit]),
    .phase       (phase_q),
    .ch          (ch_raw)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= 2'd0;
      en_raw_q <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      phase_q  <= isp_ctrl[CtrlPhaseHi:CtrlPhaseLo];
      en_raw_q <= isp_ctrl[CtrlBlcBit] & isp_ctrl[CtrlEnBit];
      en_q     <= en_raw_q;
    end
  end

  // Stage 1: subtract with floor; disabled pixels pass through untouched.
  always_comb begin
    off_sel = off_sh_q[ch0];
    d1_d    = data0_q;
    clip_d  = 1'b0;
    if (en_q) begin
      if (data0_q < off_sel) begin
        d1_d   = '0;
        clip_d = 1'b1;
      end else begin
        d1_d = data0_q - off_sel;
      end
    end
  end

  // Stage 3: round half up, drop the 12 fraction bits, saturate to DATA_WIDTH.
  always_comb begin
    rnd      = {1'b0, p2_q} + (PW+1)'(Q412One >> 1);
    q        = rnd[PW:Q412Frac];
    sat      = |q[PW-Q412Frac:DATA_WIDTH];
    stage3_d = !en2_q ? d2_q : (sat ? '1 : q[DATA_WIDTH-1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      data0_q    <= '0;
      user0_q    <= '0;
      d1_q       <= '0;
      user1_q    <= '0;
      en1_q      <= 1'b0;
      gain1_q    <= '0;
      p2_q       <= '0;
      d2_q       <= '0;
      user2_q    <= '0;
      en2_q      <= 1'b0;
      out_data   <= '0;
      out_user   <= '0;
      clip_cnt_q <= '0;
      clip_count <= '0;
      gain_sh_q  <= '0;
      for (int k = 0; k < 4; k++) off_sh_q[k] <= '0;
    end else begin
      if (accept && frame_start_in) begin
        gain_sh_q <= blc_gain;
        for (int k = 0; k < 4; k++) off_sh_q[k] <= blc_offset[k*DATA_WIDTH +: DATA_WIDTH];
      end
      if (run) begin
        valid_q <= {valid_q[PIPELINE-2:0], in_valid};
        if (in_valid) begin
          data0_q <= in_data;
          user0_q <= in_user;
        end
        if (valid_q[0]) begin
          d1_q    <= d1_d;
          user1_q <= user0_q;
          en1_q   <= en_q;
          // Gain travels with the pixel so a frame boundary inside the pipe is clean.
          gain1_q <= gain_sh_q;
          if (frame_start_s0) begin
            clip_count <= clip_cnt_q;
            clip_cnt_q <= {23'd0, clip_d};
          end else if (clip_d && clip_cnt_q != '1) begin
            clip_cnt_q <= clip_cnt_q + 24'd1;
          end
        end
        if (valid_q[1]) begin
          p2_q    <= PW'(d1_q) * PW'(gain1_q);
          d2_q    <= d1_q;
          user2_q <= user1_q;
          en2_q   <= en1_q;
        end
        if (valid_q[2]) begin
          out_data <= stage3_d;
          out_user <= user2_q;
        end
      end
    end
  end

endmodule
